wddl_rail_decoder: RTL
======================

Name: wddl_rail_decoder

Overview:
- Receiver end of the WDDL dual-rail datapath. It converts precharged dual-rail words (true/false rail pairs, return-to-spacer) back into single-rail registered data with a valid/ready handshake.
- It sits at the boundary where the WDDL AES core hands state bytes to the single-rail control/output logic.
- It enforces the spacer→codeword→spacer protocol and flags illegal encodings, rail withdrawal and evaluation timeouts.

Parameters:
- WIDTH, 8, number of dual-rail bit pairs (one AES byte).
- TIMEOUT, 16, maximum cycles a partial (incomplete) codeword may persist in evaluation before error.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din_t  input  WIDTH  true rails from the WDDL datapath.
- din_f  input  WIDTH  false rails from the WDDL datapath.
- dout  output  WIDTH  decoded single-rail word.
- dout_valid  output  1  dout holds a decoded word.
- dout_ready  input  1  consumer accepts dout when high together with dout_valid.
- err  output  1  sticky protocol error.
- err_code  output  2  0 none, 1 illegal (11) pair, 2 rail withdrawal, 3 timeout.
- err_clr  input  1  clears err/err_code; FSM returns to S_SPACER.
- word_cnt  output  CNT_W  count of handshaked words.

Behaviour:
- Reset values:
  - dout=0, dout_valid=0, err=0, err_code=0, word_cnt=0.
  - Input registers cleared; FSM enters S_SPACER.
- Input stage: din_t/din_f are registered once (t_q/f_q). All classification uses the registered values.
- Per-bit classification:
  - 00 = spacer.
  - 01/10 = valid (value = t rail).
  - 11 = illegal.
- Word-level signals:
  - all_spacer = every pair 00.
  - all_valid = every pair 01/10.
  - any_illegal = at least one pair 11.
- FSM states S_SPACER, S_EVAL, S_HOLD, S_ERR:
  - S_SPACER:
    - any_illegal → S_ERR, code 1.
    - Else all_spacer → S_EVAL.
    - Other partial states are ignored here (late precharge).
  - S_EVAL:
    - Keeps mask of rails seen high (hi_q).
    - Priority: any_illegal → S_ERR code 1; else a rail in hi_q now low → S_ERR code 2; else all_valid → dout<=t_q, dout_valid<=1 → S_HOLD; else timer++.
    - Timer is zeroed on entry. The timer reaching TIMEOUT while still partial → S_ERR code 3.
    - All-spacer cycles do not advance the timer.
  - S_HOLD:
    - dout and dout_valid are held stable until dout_valid&&dout_ready.
    - On that cycle: dout_valid<=0, word_cnt++ (wraps modulo 2^CNT_W), → S_SPACER.
    - any_illegal while holding → S_ERR code 1, dout_valid<=0, word not counted.
    - Inputs returning to spacer while held is legal and ignored.
  - S_ERR:
    - err=1, dout_valid=0, code frozen at its first cause.
    - err_clr → err=0, code=0, → S_SPACER.
    - err_clr in any other state has no effect.
- Latency: a complete codeword present on din at edge N is registered at edge N+1; dout_valid is high after edge N+2.
- Throughput: one word per spacer/evaluate wave. A second codeword arriving without an intervening all-spacer sample is not accepted.
- Ready may be held high constantly. The handshake completes on the first cycle dout_valid is high.
- rst mid-operation overrides everything: a held word is discarded and the counter is cleared.

Decomposition:
- Shared package wddl_pkg:
  - State enum (S_SPACER, S_EVAL, S_HOLD, S_ERR).
  - err_code enum (ERR_NONE, ERR_ILLEGAL, ERR_WITHDRAW, ERR_TIMEOUT).
  - Rail-pair encoding constants (SPACER=2'b00, ONE=2'b10, ZERO=2'b01, ILLEGAL=2'b11), ordered {t,f}.
- Sub-module wddl_pair_classify: purely combinational WIDTH-wide classification producing all_spacer, all_valid, any_illegal. It is reused by future dual-rail checkers.

Test Plan:
- Nominal word, ready=1:
  - Stimulus: spacer 3 cycles, then din_t=8'hA5, din_f=8'h5A.
  - Response: dout=8'hA5 and dout_valid high 2 cycles after the codeword appears, high for 1 cycle; word_cnt=1.
- Backpressure:
  - Stimulus: codeword 8'h3C, ready=0 for 5 cycles, inputs returning to spacer meanwhile.
  - Response: dout stable at 8'h3C with dout_valid=1 throughout; accepted on the ready cycle; word_cnt increments once.
- Illegal pair:
  - Stimulus: in S_EVAL drive din_t=8'h01, din_f=8'h01.
  - Response: err=1, err_code=1, dout_valid=0.
  - Stimulus: err_clr pulse.
  - Response: err=0; the next spacer+codeword 8'hFF decodes to dout=8'hFF.
- Withdrawal:
  - Stimulus: partial word with t[0]=1, then t[0] drops to 0 before completion.
  - Response: err_code=2.
- Timeout:
  - Stimulus: hold a partial word (bits 0..6 valid, bit 7 spacer) for TIMEOUT cycles.
  - Response: err_code=3.
  - Stimulus: hold the same partial word for 15 cycles and then complete it.
  - Response: no error.
- Missing spacer and reset:
  - Stimulus: two back-to-back codewords with no spacer between them.
  - Response: only the first is decoded.
  - Stimulus: assert rst while in S_HOLD.
  - Response: dout_valid=0, word_cnt=0 the next cycle.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 words.
  - Response: word_cnt=1.

Source files
------------

// File: rtl/wddl_pkg.sv
// Shared definitions for the WDDL dual-rail receive path.
package wddl_pkg;

  // Rail-pair encodings, ordered {t, f}
  localparam logic [1:0] SPACER  = 2'b00;
  localparam logic [1:0] ONE     = 2'b10;
  localparam logic [1:0] ZERO    = 2'b01;
  localparam logic [1:0] ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_SPACER,
    S_EVAL,
    S_HOLD,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ILLEGAL,
    ERR_WITHDRAW,
    ERR_TIMEOUT
  } err_code_e;

endpackage

// File: rtl/wddl_pair_classify.sv
// Word-level classification of WIDTH dual-rail pairs (purely combinational).
module wddl_pair_classify
  import wddl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_t,
  input  logic [WIDTH-1:0] i_f,
  output logic             o_all_spacer,
  output logic             o_all_valid,
  output logic             o_any_illegal
);

  // Fold every pair's encoding into the three word-level flags
  always_comb begin
    o_all_spacer  = 1'b1;
    o_all_valid   = 1'b1;
    o_any_illegal = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      unique case ({i_t[i], i_f[i]})
        SPACER:    o_all_valid = 1'b0;
        ONE, ZERO: o_all_spacer = 1'b0;
        ILLEGAL: begin
          o_all_spacer  = 1'b0;
          o_all_valid   = 1'b0;
          o_any_illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/wddl_rail_decoder.sv
// Dual-rail (WDDL, return-to-spacer) to single-rail decoder with valid/ready
// output, sticky protocol error reporting and an accepted-word counter.
module wddl_rail_decoder
  import wddl_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_t,
  input  logic [WIDTH-1:0] din_f,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             err_clr,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WIDTH-1:0]   r_t, r_f;
  logic [2*WIDTH-1:0] w_rails;
  logic               w_all_spacer, w_all_valid, w_any_illegal;

  state_e             r_state, w_state_n;
  err_code_e          r_code, w_code_n;
  logic [WIDTH-1:0]   r_dout, w_dout_n;
  logic               r_valid, w_valid_n;
  logic               r_err, w_err_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [TW-1:0]      r_timer, w_timer_n;
  logic [2*WIDTH-1:0] r_hi, w_hi_n;

  // Single input register stage; everything downstream sees only r_t/r_f
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t <= '0;
      r_f <= '0;
    end else begin
      r_t <= din_t;
      r_f <= din_f;
    end
  end

  assign w_rails = {r_t, r_f};

  wddl_pair_classify #(.WIDTH(WIDTH)) u_classify (
    .i_t           (r_t),
    .i_f           (r_f),
    .o_all_spacer  (w_all_spacer),
    .o_all_valid   (w_all_valid),
    .o_any_illegal (w_any_illegal)
  );

  // Next-state and next-output logic for the spacer/evaluate/hold/error cycle
  always_comb begin
    w_state_n = r_state;
    w_code_n  = r_code;
    w_dout_n  = r_dout;
    w_valid_n = r_valid;
    w_err_n   = r_err;
    w_cnt_n   = r_cnt;
    w_timer_n = r_timer;
    w_hi_n    = r_hi;
    unique case (r_state)
      S_SPACER: begin
        w_timer_n = '0;
        w_hi_n    = '0;
        if (w_any_illegal) begin
          w_state_n = S_ERR;
          w_err_n   = 1'b1;
          w_code_n  = ERR_ILLEGAL;
        end else if (w_all_spacer) begin
          w_state_n = S_EVAL;
        end
      end
      S_EVAL: begin
        w_hi_n = r_hi | w_rails;
        if (w_any_illegal) begin
          w_state_n = S_ERR;
          w_err_n   = 1'b1;
          w_code_n  = ERR_ILLEGAL;
        end else if (|(r_hi & ~w_rails)) begin
          w_state_n = S_ERR;
          w_err_n   = 1'b1;
          w_code_n  = ERR_WITHDRAW;
        end else if (w_all_valid) begin
          w_dout_n  = r_t;
          w_valid_n = 1'b1;
          w_state_n = S_HOLD;
        end else if (!w_all_spacer) begin
          // Timer counts partial samples already seen; the TIMEOUT-th one errors
          if (r_timer == TW'(TIMEOUT - 1)) begin
            w_state_n = S_ERR;
            w_err_n   = 1'b1;
            w_code_n  = ERR_TIMEOUT;
          end else begin
            w_timer_n = r_timer + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (w_any_illegal) begin
          w_state_n = S_ERR;
          w_err_n   = 1'b1;
          w_code_n  = ERR_ILLEGAL;
          w_valid_n = 1'b0;
        end else if (dout_ready) begin
          w_valid_n = 1'b0;
          w_cnt_n   = r_cnt + 1'b1;
          w_state_n = S_SPACER;
        end
      end
      S_ERR: begin
        if (err_clr) begin
          w_err_n   = 1'b0;
          w_code_n  = ERR_NONE;
          w_state_n = S_SPACER;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_SPACER;
      r_code  <= ERR_NONE;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_timer <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_state_n;
      r_code  <= w_code_n;
      r_dout  <= w_dout_n;
      r_valid <= w_valid_n;
      r_err   <= w_err_n;
      r_cnt   <= w_cnt_n;
      r_timer <= w_timer_n;
      r_hi    <= w_hi_n;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign err        = r_err;
  assign err_code   = r_code;
  assign word_cnt   = r_cnt;

endmodule
